// File: rtl/grid_pkg.sv
// grid_pkg: shared FSM state type and default geometry for the grid overlay controller
package grid_pkg;

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      IN_LINE    = 2'd1,
      LINE_GAP   = 2'd2,
      FRAME_DONE = 2'd3
   } state_t;

   localparam int DEF_SCALE    = 4;
   localparam int DEF_GRID_W   = 1;
   localparam int DEF_H_ACTIVE = 960;
   localparam int DEF_V_ACTIVE = 640;

endpackage

// File: rtl/grid_axis_cnt.sv
// grid_axis_cnt: modulo-SCALE sub-position counter plus saturating index counter for one axis
module grid_axis_cnt
   import grid_pkg::*;
#(
   parameter int SCALE = DEF_SCALE,
   parameter int MAX   = DEF_H_ACTIVE,
   localparam int SW   = $clog2(SCALE),
   localparam int IW   = $clog2(MAX + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [SW-1:0] sub,
   output logic [IW-1:0] idx
);

   logic wrap;
   logic sat;

   assign wrap = sub == SW'(SCALE - 1);
   assign sat  = idx == IW'(MAX);

   // clear has priority; sub wraps modulo SCALE while idx sticks at MAX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub <= '0;
         idx <= '0;
      end else if (clr) begin
         sub <= '0;
         idx <= '0;
      end else if (inc) begin
         sub <= wrap ? '0 : sub + 1'b1;
         idx <= sat ? idx : idx + 1'b1;
      end
   end

endmodule

// File: rtl/grid_ctrl.sv
// grid_ctrl: per-pixel grid overlay control with frame/line tracking and geometry error flag
module grid_ctrl
   import grid_pkg::*;
#(
   parameter int SCALE    = DEF_SCALE,
   parameter int GRID_W   = DEF_GRID_W,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_ACTIVE = DEF_V_ACTIVE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pxlEn,
   input  logic de,
   input  logic vsync,
   input  logic cfgGridEn,
   input  logic cfgBright,
   input  logic cfgMult,
   output logic gridAct,
   output logic brightGrid,
   output logic gridMult,
   output logic pxlValid,
   output logic lineErr
);

   localparam int SW = $clog2(SCALE);
   localparam int CW = $clog2(H_ACTIVE + 1);
   localparam int LW = $clog2(V_ACTIVE + 1);

   state_t        state, state_nxt;
   logic          vs_q, armed, en_s;
   logic [SW-1:0] sub_x, sub_y;
   logic [CW-1:0] col_cnt;
   logic [LW-1:0] line_cnt;
   logic          vs_rise, pix, done, in_frame, act_pix, line_end;
   logic          col_ok, on_line, grid_nxt, err_set;

   grid_axis_cnt #(.SCALE(SCALE), .MAX(H_ACTIVE)) u_x (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (vs_rise | line_end),
      .inc  (act_pix),
      .sub  (sub_x),
      .idx  (col_cnt)
   );

   grid_axis_cnt #(.SCALE(SCALE), .MAX(V_ACTIVE)) u_y (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (vs_rise),
      .inc  (line_end),
      .sub  (sub_y),
      .idx  (line_cnt)
   );

   // per-pixel decode and next state; a vsync edge swallows any pixel in the same cycle
   always_comb begin
      vs_rise  = vsync & ~vs_q;
      pix      = pxlEn & de & ~vs_rise;
      done     = line_cnt == LW'(V_ACTIVE);
      in_frame = (state == IN_LINE) | ((state == LINE_GAP) & ~done) | ((state == WAIT_FRAME) & armed);
      act_pix  = pix & in_frame;
      line_end = pxlEn & ~de & ~vs_rise & (state == IN_LINE);
      col_ok   = col_cnt < CW'(H_ACTIVE);
      on_line  = (sub_x < SW'(GRID_W)) | (sub_y < SW'(GRID_W));
      grid_nxt = en_s & act_pix & col_ok & on_line;
      err_set  = (act_pix & ~col_ok) | (line_end & col_ok) | (pix & ~in_frame & (state != WAIT_FRAME));
      state_nxt = state;
      if (vs_rise)
         state_nxt = WAIT_FRAME;
      else
         case (state)
            WAIT_FRAME: state_nxt = act_pix ? IN_LINE : WAIT_FRAME;
            IN_LINE:    state_nxt = line_end ? LINE_GAP : IN_LINE;
            LINE_GAP:   state_nxt = (pxlEn & done) ? FRAME_DONE : act_pix ? IN_LINE : LINE_GAP;
            default:    state_nxt = FRAME_DONE;
         endcase
   end

   // frame tracking state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= WAIT_FRAME;
      else
         state <= state_nxt;
   end

   // vsync edge detect, shadow config capture and registered pixel controls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q       <= 1'b1;
         armed      <= 1'b0;
         en_s       <= 1'b0;
         brightGrid <= 1'b0;
         gridMult   <= 1'b0;
         gridAct    <= 1'b0;
         pxlValid   <= 1'b0;
         lineErr    <= 1'b0;
      end else begin
         vs_q     <= vsync;
         gridAct  <= grid_nxt;
         pxlValid <= pxlEn & de;
         lineErr  <= ~vs_rise & (lineErr | err_set);
         if (vs_rise) begin
            armed      <= 1'b1;
            en_s       <= cfgGridEn;
            brightGrid <= cfgBright;
            gridMult   <= cfgMult;
         end
      end
   end

endmodule

// File: tb/tb_grid_ctrl.sv
// tb_grid_ctrl: randomized and directed checks of grid_ctrl against a frame/line/column model
module tb_grid_ctrl;

   localparam int S = 4;
   localparam int G = 1;
   localparam int H = 8;
   localparam int V = 8;

   logic clk = 1'b0;
   logic rst_n, pxlEn, de, vsync, cfgGridEn, cfgBright, cfgMult;
   logic gridAct, brightGrid, gridMult, pxlValid, lineErr;

   int tests = 0;
   int fails = 0;
   bit chk_en = 0;

   // model state: position in the frame as the bench drives it
   bit m_vs, m_armed, m_en, m_br, m_mu, m_open, m_err;
   int m_line, m_col;
   logic [4:0] exp_nxt, exp_q;

   logic [15:0] row;
   int ci;

   grid_ctrl #(.SCALE(S), .GRID_W(G), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pxlEn     (pxlEn),
      .de        (de),
      .vsync     (vsync),
      .cfgGridEn (cfgGridEn),
      .cfgBright (cfgBright),
      .cfgMult   (cfgMult),
      .gridAct   (gridAct),
      .brightGrid(brightGrid),
      .gridMult  (gridMult),
      .pxlValid  (pxlValid),
      .lineErr   (lineErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, want, $time);
      end
   endtask

   task automatic m_reset();
      m_vs = 1; m_armed = 0; m_en = 0; m_br = 0; m_mu = 0;
      m_open = 0; m_err = 0; m_line = 0; m_col = 0;
      exp_nxt = '0;
   endtask

   // expected outputs after the coming edge, from frame geometry and current inputs
   task automatic model_step();
      bit vr, g;
      if (!rst_n) begin
         m_reset();
         return;
      end
      vr = vsync & ~m_vs;
      m_vs = vsync;
      g = 0;
      if (vr) begin
         m_armed = 1; m_en = cfgGridEn; m_br = cfgBright; m_mu = cfgMult;
         m_line = 0; m_col = 0; m_open = 0; m_err = 0;
      end else if (pxlEn && de) begin
         if (m_armed) begin
            if (m_line >= V) m_err = 1;
            else begin
               g = m_en && (m_col < H) && ((m_col % S) < G || (m_line % S) < G);
               if (m_col >= H) m_err = 1;
               m_col++;
               m_open = 1;
            end
         end
      end else if (pxlEn && m_open) begin
         if (m_col < H) m_err = 1;
         m_line++;
         m_col = 0;
         m_open = 0;
      end
      exp_nxt = {g, m_br, m_mu, pxlEn & de, m_err};
   endtask

   task automatic step(input logic pe, input logic d, input logic vs);
      pxlEn = pe; de = d; vsync = vs;
      model_step();
      @(posedge clk);
      #1;
      exp_q = exp_nxt;
      if (pe && d && ci < 16) begin
         row[ci] = gridAct;
         ci++;
      end
   endtask

   task automatic pix_cyc(input logic d, input int mode);
      int idle;
      idle = (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (idle) step(1'b0, 1'($urandom % 2), 1'b0);
      step(1'b1, d, 1'b0);
   endtask

   task automatic pixels(input int n, input int mode);
      row = '0;
      ci = 0;
      for (int i = 0; i < n; i++) pix_cyc(1'b1, mode);
   endtask

   task automatic send_line(input int n, input int mode);
      pixels(n, mode);
      pix_cyc(1'b0, mode);
   endtask

   task automatic vs_pulse(input logic en, input logic br, input logic mu, input logic pe);
      cfgGridEn = en; cfgBright = br; cfgMult = mu;
      step(pe, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
   endtask

   // every cycle outside the reset prologue the registered outputs must match the model
   always @(negedge clk)
      if (chk_en)
         chk("cycle", {11'd0, gridAct, brightGrid, gridMult, pxlValid, lineErr}, {11'd0, exp_q});

   initial begin
      rst_n = 0; pxlEn = 0; de = 0; vsync = 1;
      cfgGridEn = 1; cfgBright = 1; cfgMult = 1;
      row = '0; ci = 0;
      m_reset();
      exp_q = '0;
      repeat (3) step(1'b0, 1'b0, 1'b1);
      rst_n = 1;
      chk("reset", {11'd0, gridAct, brightGrid, gridMult, pxlValid, lineErr}, 16'd0);
      chk_en = 1;

      // vsync held high through reset is no edge: grid stays off
      send_line(H, 0);
      chk("pre_vsync_row", row, 16'h0000);
      step(1'b0, 1'b0, 1'b0);

      // basic 8x8 frame
      vs_pulse(1, 1, 0, 0);
      for (int l = 0; l < V; l++) begin
         send_line(H, 0);
         chk($sformatf("row%0d", l), row, (l % S == 0) ? 16'h00FF : 16'h0011);
      end
      step(1'b1, 1'b0, 1'b0);
      chk("frame_clean_err", {15'd0, lineErr}, 16'd0);

      // cfg change mid-frame waits for the next vsync
      vs_pulse(1, 0, 1, 0);
      for (int l = 0; l < V; l++) begin
         if (l == 3) cfgGridEn = 0;
         send_line(H, 0);
         if (l == 4) chk("shadow_row4", row, 16'h00FF);
      end
      vs_pulse(0, 0, 1, 0);
      send_line(H, 0);
      chk("disabled_row0", row, 16'h0000);

      // sparse strobes
      vs_pulse(1, 0, 0, 0);
      send_line(H, 1);
      chk("sparse_row0", row, 16'h00FF);
      send_line(H, 1);
      chk("sparse_row1", row, 16'h0011);

      // overlong line
      vs_pulse(1, 0, 0, 0);
      send_line(H + 2, 0);
      chk("long_row", row, 16'h00FF);
      chk("long_err", {15'd0, lineErr}, 16'd1);
      send_line(H, 0);
      chk("long_err_sticky", {15'd0, lineErr}, 16'd1);
      vs_pulse(1, 0, 0, 0);
      chk("err_cleared", {15'd0, lineErr}, 16'd0);

      // vsync in the middle of line 3 restarts the frame
      for (int l = 0; l < 3; l++) send_line(H, 0);
      pixels(3, 0);
      chk("line3_part", row, 16'h0001);
      vs_pulse(1, 0, 0, 0);
      send_line(H, 0);
      chk("restart_row0", row, 16'h00FF);
      chk("restart_err", {15'd0, lineErr}, 16'd0);

      // asynchronous reset mid-line
      vs_pulse(1, 1, 1, 0);
      pixels(3, 0);
      #2;
      rst_n = 0;
      m_reset();
      exp_q = '0;
      #1;
      chk("async_reset", {11'd0, gridAct, brightGrid, gridMult, pxlValid, lineErr}, 16'd0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      rst_n = 1;
      send_line(H, 0);
      chk("post_reset_row", row, 16'h0000);
      vs_pulse(1, 0, 0, 0);
      send_line(H, 0);
      chk("resume_row0", row, 16'h00FF);

      // randomized frames with geometry faults, cfg noise and early vsyncs
      for (int f = 0; f < 12; f++) begin
         int nl;
         vs_pulse(1'($urandom % 4 != 0), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
         nl = V + (($urandom % 4 == 0) ? int'($urandom_range(0, 2)) - 1 : 0);
         for (int l = 0; l < nl; l++) begin
            int w;
            w = H + (($urandom % 5 == 0) ? int'($urandom_range(0, 2)) - 1 : 0);
            if ($urandom % 6 == 0) begin
               cfgGridEn = 1'($urandom % 2);
               cfgBright = 1'($urandom % 2);
               cfgMult   = 1'($urandom % 2);
            end
            if ($urandom % 25 == 0) begin
               pixels(int'($urandom_range(1, H)), 2);
               break;
            end
            send_line(w, 2);
         end
         repeat (int'($urandom_range(1, 4))) pix_cyc(1'($urandom % 3 == 0), 2);
      end

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
